iob_reg_arbiter: RTL
====================

Name: iob_reg_arbiter

Overview:
Round-robin write arbiter sharing one DATA_W-bit holding register between N requesters. Each requester raises a request with its data. The block grants one requester at a time, loads that requester's data into the shared register and returns a one-cycle acknowledge. It sits between multiple producer blocks and a single shared configuration/status register, sequencing all writes to it.

Parameters:
N, 4, number of requesters (N >= 2; need not be a power of two)
DATA_W, 32, width of shared register and of each requester's data
RST_VAL, 0, shared register value after reset (truncated/extended to DATA_W)

Ports:
clk  input  1  system clock, all state on rising edge
arst  input  1  asynchronous reset, active-high
rst  input  1  synchronous reset, active-high, same effect as arst but sampled on clk
req_i  input  N  per-requester write request, bit k = requester k
data_i  input  N*DATA_W  requester data, requester k at bits [k*DATA_W +: DATA_W]
grant_o  output  N  one-hot grant, all-zero when no requester owns the register
ack_o  output  N  one-hot, one-cycle write-complete pulse to the granted requester
data_o  output  DATA_W  current shared register contents
busy_o  output  1  high whenever FSM is not in IDLE

Behaviour:
- Reset (arst asynchronously, or rst at the clock edge; arst has priority): state=IDLE, priority pointer ptr=0, grant_o=0, ack_o=0, data_o=RST_VAL, busy_o=0.
- State register, grant index, ptr and shared register are all flops; data_o driven directly from the shared register flop.
- FSM states: IDLE, WRITE, ACK.
- IDLE: if req_i==0, stay. Otherwise select g = first k with req_i[k]=1, searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (modulo N). Register g and go to WRITE.
- WRITE: grant_o = one-hot(g). At the clock edge, load the shared register with data_i[g] and go to ACK.
- ACK: ack_o = one-hot(g), grant_o still one-hot(g), data_o already shows the new value. At the clock edge set ptr = (g+1) mod N, go to IDLE.
- grant_o and ack_o are 0 in every state other than those listed.
- Timing: request first sampled high at edge E0 (in IDLE) gives:
  - grant_o high during cycle after E0;
  - data_o updated and ack_o high in the cycle after E1;
  - return to IDLE at E2.
  - Minimum 3 cycles per write; a pending request arbitrates in the next IDLE cycle.
- Handshake: requester holds req_i[k] and data_i[k] stable until it sees ack_o[k], then deasserts req_i[k] in the cycle after ack (or keeps it high to queue another write).
- Requests changing while in WRITE/ACK do not affect the current grant.
- If req_i[g] drops during WRITE/ACK, the write and ack still complete; no cancel path.
- Fairness: a continuously requesting set of requesters is served in strict rotation. No requester waits more than N-1 other writes.
- ptr wrap: g=N-1 gives ptr=0. Index width is $clog2(N), and non-power-of-two N must never produce an index >= N.
- Reset mid-operation (WRITE or ACK): transaction aborted, no ack issued, shared register = RST_VAL, ptr=0.
- Simultaneous rst and request: rst wins, stay IDLE.

Test Plan:
- Single request: N=4, reset, req_i=4'b0100 with data_i[2]=0xA5A5A5A5 -> grant_o=4'b0100 one cycle later, then data_o=0xA5A5A5A5 with ack_o=4'b0100 for exactly one cycle, busy_o back to 0 after 3 cycles.
- All request at once: req_i=4'b1111, data_i[k]=k+1, each requester drops req the cycle after its ack -> acks in order 0,1,2,3, data_o sequence 1,2,3,4, 3 cycles per write.
- Fairness: req 0 held high permanently, req 2 raised after first grant to 0 -> grants alternate 0,2,0,2; ptr never lets 0 win twice while 2 pending.
- Non-power-of-two wrap: N=3, ptr advanced to 2, req_i=3'b011 -> grant 0 (wrap from index 2), then 1; no out-of-range grant.
- Reset mid-op: arst asserted asynchronously during WRITE with req_i[1] and data 0xDEAD -> data_o=RST_VAL immediately, no ack_o pulse, next arbitration starts from ptr=0.
- Sync reset priority: rst=1 in IDLE with req_i=4'b1000 -> stays IDLE, grant_o=0. After rst drops, grant 3 follows normally.

Source files
------------

// File: rtl/iob_reg_arbiter.sv
// Round-robin arbiter that serialises N requesters' writes into one shared
// DATA_W-bit register, returning a one-cycle ack to the winning requester.
module iob_reg_arbiter #(
  parameter int unsigned       N       = 4,
  parameter int unsigned       DATA_W  = 32,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic                clk,
  input  logic                arst,
  input  logic                rst,
  input  logic [N-1:0]        req_i,
  input  logic [N*DATA_W-1:0] data_i,
  output logic [N-1:0]        grant_o,
  output logic [N-1:0]        ack_o,
  output logic [DATA_W-1:0]   data_o,
  output logic                busy_o
);

  localparam int unsigned      IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(N - 1);
  localparam logic [N-1:0]     ONE   = N'(1);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    ACK
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] g;
  logic [IDX_W-1:0] sel;
  logic [N-1:0]     rot;
  logic [IDX_W:0]   sum;

  // Rotate requests so bit 0 is the pointer position; the first set bit at
  // offset i maps back to requester (ptr + i) mod N, which always stays < N.
  assign rot = N'({req_i, req_i} >> ptr);

  always_comb begin
    sel = '0;
    sum = '0;
    for (int unsigned i = N; i > 0; i--) begin
      if (rot[i-1]) begin
        sum = {1'b0, ptr} + (IDX_W+1)'(i - 1);
        if (sum >= (IDX_W+1)'(N)) begin
          sum = sum - (IDX_W+1)'(N);
        end
        sel = IDX_W'(sum);
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state   <= IDLE;
      ptr     <= '0;
      g       <= '0;
      grant_o <= '0;
      ack_o   <= '0;
      busy_o  <= 1'b0;
      data_o  <= RST_VAL;
    end else if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      g       <= '0;
      grant_o <= '0;
      ack_o   <= '0;
      busy_o  <= 1'b0;
      data_o  <= RST_VAL;
    end else begin
      case (state)
        IDLE: begin
          if (|req_i) begin
            g       <= sel;
            grant_o <= ONE << sel;
            busy_o  <= 1'b1;
            state   <= WRITE;
          end
        end
        WRITE: begin
          data_o <= data_i[g*DATA_W +: DATA_W];
          ack_o  <= ONE << g;
          state  <= ACK;
        end
        ACK: begin
          ptr     <= (g == LAST) ? '0 : g + 1'b1;
          grant_o <= '0;
          ack_o   <= '0;
          busy_o  <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          grant_o <= '0;
          ack_o   <= '0;
          busy_o  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
